regfile_mp: RTL



---
 rtl/regfile_mp.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised integer register file with NUM_READ combinational
// read ports, NUM_WRITE prioritised write ports, an optional write-to-read
// bypass and a built-in post-reset clear sequencer that zeroes every register.
module regfile_mp #(
   parameter int XLEN        = 32,
   parameter int NREGS       = 32,
   parameter int NUM_READ    = 3,
   parameter int NUM_WRITE   = 1,
   parameter int BYPASS      = 0,
   parameter int CLEAR_LANES = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_WRITE-1:0]                 wr_en,
   input  logic [NUM_WRITE*$clog2(NREGS)-1:0]   wr_sel,
   input  logic [NUM_WRITE*XLEN-1:0]            wr_data,
   input  logic [NUM_READ*$clog2(NREGS)-1:0]    rd_sel,
   output logic [NUM_READ*XLEN-1:0]             rd_data,
   output logic                                 clear_busy
);

   localparam int AW = $clog2(NREGS);
   // One extra bit so the pointer can go negative after the last partial group.
   localparam int PW = AW + 1;

   localparam logic signed [PW-1:0] TOP_S   = PW'(NREGS - 1);
   localparam logic signed [PW-1:0] LANES_S = PW'(CLEAR_LANES);
   localparam logic signed [PW-1:0] ZERO_S  = '0;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                  state;
   logic signed [PW-1:0]    ptr;
   logic signed [PW-1:0]    clear_idx [CLEAR_LANES];
   logic [XLEN-1:0]         regs [1:NREGS-1];

   // Clear sequencer: reset parks the pointer at the top register, then it
   // walks down by CLEAR_LANES per cycle until the lowest group is reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         ptr        <= TOP_S;
         clear_busy <= 1'b1;
      end else if (state == CLEAR) begin
         ptr <= ptr - LANES_S;
         if (ptr <= LANES_S) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
         end
      end
   end

   // Indices zeroed this cycle; while reset is held the top group is used.
   always_comb begin
      for (int l = 0; l < CLEAR_LANES; l++) begin
         clear_idx[l] = (rst ? TOP_S : ptr) - PW'(l);
      end
   end

   // Storage update: clearing has priority, otherwise ports write in
   // ascending order so the highest-numbered port to the same index wins.
   always_ff @(posedge clk) begin
      if (rst || state == CLEAR) begin
         for (int l = 0; l < CLEAR_LANES; l++) begin
            if (clear_idx[l] > ZERO_S) begin
               regs[clear_idx[l][AW-1:0]] <= '0;
            end
         end
      end else begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && (wr_sel[w*AW +: AW] != '0)) begin
               regs[wr_sel[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   // Combinational reads: zero while clearing or for index 0, optionally
   // overridden by the winning same-cycle write to the selected index.
   always_comb begin
      rd_data = '0;
      for (int r = 0; r < NUM_READ; r++) begin
         if (!clear_busy && (rd_sel[r*AW +: AW] != '0)) begin
            rd_data[r*XLEN +: XLEN] = regs[rd_sel[r*AW +: AW]];
            if (BYPASS != 0) begin
               for (int w = 0; w < NUM_WRITE; w++) begin
                  if (wr_en[w] && (wr_sel[w*AW +: AW] == rd_sel[r*AW +: AW])) begin
                     rd_data[r*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                  end
               end
            end
         end
      end
   end

endmodule
